// File: rtl/seq_datapath.sv
// Parametrised bus datapath: GPRs, special registers, combinational ALU into Z and a
// multi-cycle unsigned multiply/divide engine. Divider built only with SEQ_DATAPATH_DIV_EN.
//
// state | meaning
// IDLE  | engine free; Z writable from the ALU; start accepted
// RUN   | one multiply/divide step per cycle; engine owns Z
module seq_datapath #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16
) (
    input  logic                clock,
    input  logic                clear,
    input  logic [NUM_REGS-1:0] Rin,
    input  logic [NUM_REGS-1:0] Rout,
    input  logic                PCin,
    input  logic                PCout,
    input  logic                IRin,
    input  logic                IRout,
    input  logic                Yin,
    input  logic                Yout,
    input  logic                MARin,
    input  logic                MDRin,
    input  logic                MDRout,
    input  logic                HIin,
    input  logic                HIout,
    input  logic                LOin,
    input  logic                LOout,
    input  logic                Zlowin,
    input  logic                Zhighin,
    input  logic                Zlowout,
    input  logic                Zhighout,
    input  logic                Read,
    input  logic [DATA_W-1:0]   Mdatain,
    input  logic [3:0]          ALUop,
    input  logic                MulDivStart,
    input  logic                MulDivOp,
    output logic                Busy,
    output logic                Done,
    output logic                BusConflict,
    output logic [DATA_W-1:0]   BusMuxOut,
    output logic [DATA_W-1:0]   MARaddr
);
    localparam int SH_W  = $clog2(DATA_W);
    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

    typedef enum logic {IDLE, RUN} state_t;

    logic [DATA_W-1:0] gpr [NUM_REGS];
    logic [DATA_W-1:0] pc, ir, y, mar, mdr, hi, lo, zlow, zhigh;
    logic [DATA_W-1:0] bus_or;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [2*DATA_W-1:0] acc;
    logic [DATA_W-1:0]   opnd_b;
    logic [2*DATA_W-1:0] step_next;
    logic                start_ok;

    always_comb begin
        bus_or = '0;
        for (int i = 0; i < NUM_REGS; i++)
            if (Rout[i]) bus_or = bus_or | gpr[i];
        if (PCout)    bus_or = bus_or | pc;
        if (IRout)    bus_or = bus_or | ir;
        if (Yout)     bus_or = bus_or | y;
        if (MDRout)   bus_or = bus_or | mdr;
        if (HIout)    bus_or = bus_or | hi;
        if (LOout)    bus_or = bus_or | lo;
        if (Zlowout)  bus_or = bus_or | zlow;
        if (Zhighout) bus_or = bus_or | zhigh;
    end

    assign BusMuxOut   = bus_or;
    assign BusConflict = ($countones({Rout, PCout, IRout, Yout, MDRout, HIout, LOout,
                                      Zlowout, Zhighout}) > 1);
    assign MARaddr     = mar;

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            for (int i = 0; i < NUM_REGS; i++) gpr[i] <= '0;
            pc  <= '0;
            ir  <= '0;
            y   <= '0;
            mar <= '0;
            mdr <= '0;
            hi  <= '0;
            lo  <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++)
                if (Rin[i]) gpr[i] <= bus_or;
            if (PCin)  pc  <= bus_or;
            if (IRin)  ir  <= bus_or;
            if (Yin)   y   <= bus_or;
            if (MARin) mar <= bus_or;
            if (HIin)  hi  <= bus_or;
            if (LOin)  lo  <= bus_or;
            if (MDRin) mdr <= Read ? Mdatain : bus_or;
        end
    end

    // ALU: A = Y, B = bus; the high half of the result is always zero
    logic [SH_W-1:0]     sh;
    logic [2*DATA_W-1:0] rol_t, ror_t;
    logic [DATA_W-1:0]   alu_lo, alu_hi;

    assign sh     = bus_or[SH_W-1:0];
    assign rol_t  = {y, y} << sh;
    assign ror_t  = {y, y} >> sh;
    assign alu_hi = '0;

    always_comb begin
        alu_lo = '0;
        case (ALUop)
            4'd0:    alu_lo = y + bus_or;
            4'd1:    alu_lo = y - bus_or;
            4'd2:    alu_lo = y & bus_or;
            4'd3:    alu_lo = y | bus_or;
            4'd4:    alu_lo = y << sh;
            4'd5:    alu_lo = y >> sh;
            4'd6:    alu_lo = $unsigned($signed(y) >>> sh);
            4'd7:    alu_lo = rol_t[2*DATA_W-1:DATA_W];
            4'd8:    alu_lo = ror_t[DATA_W-1:0];
            4'd9:    alu_lo = '0 - bus_or;
            4'd10:   alu_lo = ~bus_or;
            default: alu_lo = '0;
        endcase
    end

    // Shift-add multiply: acc = {partial product, remaining multiplier bits}
    logic [DATA_W:0]     mul_sum;
    logic [2*DATA_W-1:0] mul_next;

    assign mul_sum  = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, opnd_b} : '0);
    assign mul_next = {mul_sum, acc[DATA_W-1:1]};

`ifdef SEQ_DATAPATH_DIV_EN
    // Restoring divide: acc = {remainder, dividend bits shifting into quotient}
    logic              op_div;
    logic              div_zero;
    logic [DATA_W:0]   rem_shift, trial;
    logic [2*DATA_W-1:0] div_next;

    assign rem_shift = {acc[2*DATA_W-1:DATA_W], acc[DATA_W-1]};
    assign trial     = rem_shift - {1'b0, opnd_b};
    assign div_next  = trial[DATA_W] ? {rem_shift[DATA_W-1:0], acc[DATA_W-2:0], 1'b0}
                                     : {trial[DATA_W-1:0],     acc[DATA_W-2:0], 1'b1};
    assign step_next = op_div ? div_next : mul_next;
    assign start_ok  = MulDivStart;
`else
    assign step_next = mul_next;
    assign start_ok  = MulDivStart & ~MulDivOp;
`endif

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state  <= IDLE;
            cnt    <= '0;
            acc    <= '0;
            opnd_b <= '0;
            zlow   <= '0;
            zhigh  <= '0;
            Busy   <= 1'b0;
            Done   <= 1'b0;
`ifdef SEQ_DATAPATH_DIV_EN
            op_div   <= 1'b0;
            div_zero <= 1'b0;
`endif
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (Zlowin)  zlow  <= alu_lo;
                    if (Zhighin) zhigh <= alu_hi;
                    if (start_ok) begin
                        state  <= RUN;
                        Busy   <= 1'b1;
                        cnt    <= '0;
                        opnd_b <= bus_or;
                        acc    <= {{DATA_W{1'b0}}, y};
`ifdef SEQ_DATAPATH_DIV_EN
                        op_div   <= MulDivOp;
                        div_zero <= MulDivOp && (bus_or == '0);
`endif
                    end
                end
                RUN: begin
                    acc <= step_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_STEP) begin
                        zhigh <= step_next[2*DATA_W-1:DATA_W];
                        zlow  <= step_next[DATA_W-1:0];
                        state <= IDLE;
                        Busy  <= 1'b0;
                        Done  <= 1'b1;
                    end
`ifdef SEQ_DATAPATH_DIV_EN
                    if (div_zero) begin
                        zlow  <= '1;
                        zhigh <= acc[DATA_W-1:0];
                        state <= IDLE;
                        Busy  <= 1'b0;
                        Done  <= 1'b1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_datapath.sv
// Self-checking bench for seq_datapath (DATA_W=32, NUM_REGS=16): directed scenarios plus
// random ALU and multiply/divide operations compared against an arithmetic reference model.
module tb_seq_datapath;
    localparam int W = 32;
    localparam int N = 16;

    logic          clock = 1'b0;
    logic          clear;
    logic [N-1:0]  Rin, Rout;
    logic          PCin, PCout, IRin, IRout, Yin, Yout, MARin, MDRin, MDRout;
    logic          HIin, HIout, LOin, LOout, Zlowin, Zhighin, Zlowout, Zhighout;
    logic          Read;
    logic [W-1:0]  Mdatain;
    logic [3:0]    ALUop;
    logic          MulDivStart, MulDivOp;
    logic          Busy, Done, BusConflict;
    logic [W-1:0]  BusMuxOut, MARaddr;

    int n_cmp = 0;
    int n_bad = 0;
    logic [W-1:0] zl_m = '0;
    logic [W-1:0] zh_m = '0;

    seq_datapath #(.DATA_W(W), .NUM_REGS(N)) dut (
        .clock(clock), .clear(clear), .Rin(Rin), .Rout(Rout),
        .PCin(PCin), .PCout(PCout), .IRin(IRin), .IRout(IRout),
        .Yin(Yin), .Yout(Yout), .MARin(MARin), .MDRin(MDRin), .MDRout(MDRout),
        .HIin(HIin), .HIout(HIout), .LOin(LOin), .LOout(LOout),
        .Zlowin(Zlowin), .Zhighin(Zhighin), .Zlowout(Zlowout), .Zhighout(Zhighout),
        .Read(Read), .Mdatain(Mdatain), .ALUop(ALUop),
        .MulDivStart(MulDivStart), .MulDivOp(MulDivOp),
        .Busy(Busy), .Done(Done), .BusConflict(BusConflict),
        .BusMuxOut(BusMuxOut), .MARaddr(MARaddr)
    );

    always #5 clock = ~clock;

    task automatic clr();
        Rin = '0; Rout = '0;
        PCin = 0; PCout = 0; IRin = 0; IRout = 0; Yin = 0; Yout = 0;
        MARin = 0; MDRin = 0; MDRout = 0; HIin = 0; HIout = 0; LOin = 0; LOout = 0;
        Zlowin = 0; Zhighin = 0; Zlowout = 0; Zhighout = 0;
        Read = 0; Mdatain = '0; ALUop = '0; MulDivStart = 0; MulDivOp = 0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic load_mdr(input logic [W-1:0] v);
        clr(); Mdatain = v; Read = 1; MDRin = 1; tick(); clr();
    endtask

    task automatic set_y(input logic [W-1:0] v);
        load_mdr(v); MDRout = 1; Yin = 1; tick(); clr();
    endtask

    task automatic check_z(input string tag);
        clr(); Zlowout = 1; #1 check({tag, ".zlow"}, BusMuxOut, zl_m);
        Zlowout = 0; Zhighout = 1; #1 check({tag, ".zhigh"}, BusMuxOut, zh_m);
        clr();
    endtask

    // Reference ALU written from the operation definitions using wide arithmetic.
    function automatic logic [W-1:0] ref_alu(input int op, input logic [W-1:0] a, input logic [W-1:0] b);
        int s;
        longint sa, p, q;
        logic [2*W-1:0] t;
        s = int'(b % 32);
        case (op)
            0: return a + b;
            1: return a - b;
            2: return a & b;
            3: return a | b;
            4: return a << s;
            5: return a >> s;
            6: begin
                sa = longint'($signed(a));
                p  = longint'(1) << s;
                q  = (sa >= 0) ? sa / p : -((-sa + p - 1) / p);
                return q[W-1:0];
            end
            7: begin t = {32'b0, a} << s; return t[W-1:0] | t[2*W-1:W]; end
            8: begin t = {a, 32'b0} >> s; return t[2*W-1:W] | t[W-1:0]; end
            9: return 32'd0 - b;
            10: return ~b;
            default: return '0;
        endcase
    endfunction

    task automatic alu_op(input string tag, input int op, input logic [W-1:0] a, input logic [W-1:0] b);
        set_y(a);
        load_mdr(b);
        MDRout = 1; ALUop = 4'(op); Zlowin = 1; Zhighin = 1;
        tick(); clr();
        zl_m = ref_alu(op, a, b);
        zh_m = '0;
        check_z(tag);
    endtask

    // Starts an operation and watches a fixed 40-cycle window; zin_cyc >= 0 pulses Zlowin mid-run.
    task automatic muldiv(input string tag, input bit op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int zin_cyc);
        int busy_n, done_n, overlap, busy_exp, done_exp;
        logic [2*W-1:0] prod;
        set_y(a);
        load_mdr(b);
        MDRout = 1; MulDivStart = 1; MulDivOp = op;
        tick(); clr();
        busy_n = 0; done_n = 0; overlap = 0;
        for (int c = 0; c < 40; c++) begin
            if (Busy) busy_n++;
            if (Done) done_n++;
            if (Done && Busy) overlap++;
            if (c == zin_cyc) begin Zlowin = 1; Zhighin = 1; ALUop = 4'd0; end
            tick(); clr();
            if (c == zin_cyc) begin
                Zlowout = 1; #1 check({tag, ".zlow_midrun"}, BusMuxOut, zl_m); clr();
            end
        end
        if (op == 1'b0) begin
            busy_exp = W; done_exp = 1;
            prod = {32'b0, a} * {32'b0, b};
            zl_m = prod[W-1:0]; zh_m = prod[2*W-1:W];
        end else begin
`ifdef SEQ_DATAPATH_DIV_EN
            done_exp = 1;
            if (b == 0) begin
                busy_exp = 1; zl_m = '1; zh_m = a;
            end else begin
                busy_exp = W; zl_m = a / b; zh_m = a % b;
            end
`else
            busy_exp = 0; done_exp = 0;
`endif
        end
        check({tag, ".busy_cycles"}, W'(busy_n), W'(busy_exp));
        check({tag, ".done_pulses"}, W'(done_n), W'(done_exp));
        check({tag, ".done_busy_overlap"}, W'(overlap), '0);
        check_z(tag);
    endtask

    initial begin
        logic [W-1:0] v, a, b;
        logic [W-1:0] rv [N];
        clr();
        clear = 0;
        #12;
        check("reset.busy", W'(Busy), '0);
        check("reset.done", W'(Done), '0);
        check("reset.mar", MARaddr, '0);
        Rout[0] = 1; Zlowout = 1; #1 check("reset.bus", BusMuxOut, '0); clr();
        @(negedge clock) clear = 1;
        tick();

        // MDR -> R3 -> bus
        load_mdr(32'h0000_0012);
        MDRout = 1; Rin[3] = 1; tick(); clr();
        Rout[3] = 1; #1;
        check("mdr_path.bus", BusMuxOut, 32'h0000_0012);
        check("mdr_path.conflict", W'(BusConflict), '0);
        clr();

        // every GPR holds its own random value
        for (int i = 0; i < N; i++) begin
            rv[i] = $urandom;
            load_mdr(rv[i]); MDRout = 1; Rin[i] = 1; tick(); clr();
        end
        for (int i = 0; i < N; i++) begin
            Rout[i] = 1; #1 check($sformatf("gpr%0d", i), BusMuxOut, rv[i]); clr();
        end

        // special registers and MAR
        for (int k = 0; k < 5; k++) begin
            v = $urandom;
            load_mdr(v); MDRout = 1;
            case (k) 0: PCin = 1; 1: IRin = 1; 2: HIin = 1; 3: LOin = 1; default: MARin = 1; endcase
            tick(); clr();
            case (k)
                0: PCout = 1;
                1: IRout = 1;
                2: HIout = 1;
                3: LOout = 1;
                default: ;
            endcase
            #1 check($sformatf("special%0d", k), (k == 4) ? MARaddr : BusMuxOut, v);
            clr();
        end

        // Y path and MDR bus-source select
        set_y(32'hA5A5_0F0F);
        Yout = 1; #1 check("y.bus", BusMuxOut, 32'hA5A5_0F0F); clr();
        load_mdr(32'h1234_5678);
        MDRout = 1; Rin[5] = 1; tick(); clr();
        Rout[5] = 1; MDRin = 1; Read = 0; Mdatain = 32'hDEAD_BEEF; tick(); clr();
        MDRout = 1; #1 check("mdr.from_bus", BusMuxOut, 32'h1234_5678); clr();

        alu_op("alu_add", 0, 32'd5, 32'd7);
        alu_op("alu_shra", 6, 32'h8000_0000, 32'd4);
        for (int i = 0; i < 16; i++) begin
            a = $urandom; b = $urandom;
            alu_op($sformatf("alu_rand_op%0d", i), i, a, b);
        end
        for (int i = 0; i < 6; i++) begin
            a = $urandom; b = $urandom;
            alu_op($sformatf("alu_rand_b%0d", i), int'($urandom_range(0, 10)), a, b);
        end

        muldiv("mul_dir", 1'b0, 32'hFFFF_FFFF, 32'd2, 5);
        muldiv("div_dir", 1'b1, 32'd100, 32'd7, -1);
        muldiv("div_zero", 1'b1, 32'd9, 32'd0, -1);
        for (int i = 0; i < 3; i++) begin
            a = $urandom; b = $urandom;
            muldiv($sformatf("mul_rand%0d", i), 1'b0, a, b, -1);
            a = $urandom; b = $urandom_range(1, 1000);
            muldiv($sformatf("div_rand%0d", i), 1'b1, a, b, -1);
        end

        // contention
        load_mdr(32'h0F); MDRout = 1; Rin[1] = 1; tick(); clr();
        load_mdr(32'hF0); MDRout = 1; Rin[2] = 1; tick(); clr();
        Rout[1] = 1; Rout[2] = 1; #1;
        check("conflict.flag", W'(BusConflict), 32'd1);
        check("conflict.bus", BusMuxOut, 32'h0000_00FF);
        clr();

        // reset mid-multiply
        set_y(32'h0001_2345);
        load_mdr(32'h0000_0777);
        MDRout = 1; MulDivStart = 1; MulDivOp = 0; tick(); clr();
        for (int c = 0; c < 10; c++) tick();
        check("rst_mid.busy_before", W'(Busy), 32'd1);
        #2 clear = 0;
        #1 check("rst_mid.busy", W'(Busy), '0);
        check("rst_mid.done", W'(Done), '0);
        zl_m = '0; zh_m = '0;
        Zlowout = 1; #1 check("rst_mid.zlow", BusMuxOut, zl_m);
        Zlowout = 0; Zhighout = 1; #1 check("rst_mid.zhigh", BusMuxOut, zh_m);
        clr();
        @(negedge clock) clear = 1;
        begin
            int dn;
            dn = 0;
            for (int c = 0; c < 40; c++) begin
                if (Done || Busy) dn++;
                tick();
            end
            check("rst_mid.no_done_after", W'(dn), '0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
